// File: rtl/q3_pulse_window_counter.sv
// Counts rising edges of the registered Q3 level over fixed windows of WIN_LEN
// cycles and queues each window's saturated count in a small valid/ready FIFO.
module q3_pulse_window_counter #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             out_ready,
  input  logic             clr_ovf,
  output logic [CNT_W-1:0] out_data,
  output logic             out_valid,
  output logic             ovf
);

  localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic             d_q1_q, d_q2_q;

  logic [CNT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;

  logic             rise;
  logic [CNT_W-1:0] evt_sum;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic             drop;

  assign rise    = d_q1_q & ~d_q2_q;
  // Holding at CNT_MAX keeps the counter from wrapping back to zero.
  assign evt_sum = (evt_cnt_q == CNT_MAX) ? CNT_MAX : evt_cnt_q + CNT_W'(rise);

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    evt_cnt_d = evt_cnt_q;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        win_cnt_d = '0;
        evt_cnt_d = '0;
        if (en) state_d = COUNT;
      end
      COUNT: begin
        if (!en) begin
          state_d   = IDLE;
          win_cnt_d = '0;
          evt_cnt_d = '0;
        end else if (win_cnt_q == WIN_LAST) begin
          push      = 1'b1;
          win_cnt_d = '0;
          evt_cnt_d = '0;
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
          evt_cnt_d = evt_sum;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid & out_ready;
  assign full      = (occ_q == OCC_FULL);
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    occ_d    = occ_q + OCC_W'(wr_en) - OCC_W'(pop);
    ovf_d    = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      evt_cnt_q <= '0;
      d_q1_q    <= 1'b0;
      d_q2_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      evt_cnt_q <= evt_cnt_d;
      d_q1_q    <= din;
      d_q2_q    <= d_q1_q;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= evt_sum;
  end

  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
  assign ovf      = ovf_q;

endmodule

// File: doc/q3_pulse_window_counter.md
Name: q3_pulse_window_counter

Overview:
- Downstream consumer of the top-level `Q3` net, which is the AND of the registered `Q1` and combinational `Q2`.
- Registers `Q3` and detects its rising edges.
- Counts those edges over fixed windows of WIN_LEN cycles.
- Buffers each window's count in a small FIFO, drained by a valid/ready handshake.
- Used to measure activity of the A/B/AND path without loading the C-stage input.

Parameters:
- CNT_W, 8: width of each window count; the count saturates at 2^CNT_W-1.
- WIN_LEN, 16: cycles per window; must be >= 2.
- DEPTH, 4: FIFO entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  1  Q3 level from the AND stage.
- en  in  1  counting enable.
- out_ready  in  1  consumer ready.
- clr_ovf  in  1  one-cycle clear of ovf.
- out_data  out  CNT_W  count at the FIFO head.
- out_valid  out  1  FIFO not empty.
- ovf  out  1  sticky flag: a window count was dropped.

Behaviour:
- Reset:
  - On an edge with rst=1, all state clears: state=IDLE, win_cnt=0, evt_cnt=0, FIFO pointers and occupancy 0, d_q1=d_q2=0.
  - Outputs after reset: out_valid=0, out_data=0, ovf=0.
  - rst overrides every other input, including mid-window and mid-drain. FIFO contents are discarded.
- Input stage:
  - d_q1<=din and d_q2<=d_q1 every cycle, in all states.
  - edge = d_q1 & ~d_q2.
  - A din 0->1 transition sampled at edge k makes edge=1 during cycle k..k+1. It is counted at edge k+1 if the state is COUNT.
- FSM, state IDLE:
  - win_cnt and evt_cnt are held at 0.
  - en=1 sampled at edge e -> state COUNT, with win_cnt=0 after e.
- FSM, state COUNT:
  - On every edge, evt_cnt <= sat(evt_cnt + edge).
  - win_cnt increments each edge.
  - When win_cnt==WIN_LEN-1, the next edge pushes sat(evt_cnt+edge) into the FIFO and sets evt_cnt=0, win_cnt=0.
  - One window therefore spans edges e+1..e+WIN_LEN. The push occurs at edge e+WIN_LEN, and out_valid rises after that edge.
- FSM, en=0 in COUNT:
  - en=0 sampled in COUNT -> IDLE on that edge.
  - The partial window is discarded with no push; counters go to 0.
  - A window whose final edge coincides with en=0 is also discarded.
- Saturation: sat(x) = min(x, 2^CNT_W-1). The counter never wraps.
- FIFO:
  - out_data is the head entry (0 when empty); out_valid = occupancy != 0.
  - A pop occurs when out_valid && out_ready.
  - Push with pop in the same cycle: both happen and occupancy is unchanged. This applies even when the FIFO is full.
  - Push when full with no pop: the entry is dropped and ovf<=1.
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH.
  - Output order is FIFO order.
- ovf:
  - Sticky until clr_ovf=1 or rst.
  - If clr_ovf and a new drop occur on the same edge, ovf=1 (set wins).
- Latency: din to count contribution is 2 edges; window end to out_valid is 1 edge (registered); pop to next head on out_data is 1 edge.

Test Plan:
1. Reset: rst=1 for 2 cycles, din toggling, en=1 -> out_valid=0, ovf=0, out_data=0. First push occurs WIN_LEN+1 edges after rst falls, only if en stays high.
2. Toggle: WIN_LEN=16, din=0,1,0,1..., en=1, out_ready=1 -> every window entry = 8. out_valid pulses for 1 cycle per window.
3. Single rise: din=0, then goes high at window cycle 3 and stays high -> entries 1, 0, 0. A din already high before en rises -> entry 0.
4. Saturation: CNT_W=3, WIN_LEN=32, din toggling -> entries = 7, never wrap to 0.
5. Overflow: out_ready=0, DEPTH=4, 5 windows -> out_valid=1 after window 1, 4 entries held, 5th dropped, ovf=1. Then:
   - clr_ovf pulse -> ovf=0.
   - Drain with out_ready=1 -> 4 entries in push order, then out_valid=0.
   - Full FIFO with push and pop on the same edge -> no drop, ovf stays 0.
6. Abort: en=0 at window cycle 10 -> no push, state IDLE. en=1 again -> fresh full window. rst mid-drain with 3 entries stored -> out_valid=0 on the next cycle.
